fpga_gpio_bank: RTL and testbench
=================================

# fpga_gpio_bank

Parametrised, registered GPIO pad bank for the FPGA build of retroSoC. It replaces per-pin raw `inout` wiring between the board top and the SoC pads. Per channel it provides:
- a registered output path with a push-pull or open-drain mode;
- a synchroniser, an optional debounce filter and rise/fall edge pulses on the input path.

It sits between the board-level tri-state primitives (driven from `pad_*` below) and the core-side GPIO/I2C logic, all in the `clk_i` domain.

## Interface
Parameters:
- `CH`, 16, number of channels.
- `SYNC_STAGES`, 2, input synchroniser depth. Legal range 2..4.
- `FILT_W`, 4, width of the debounce counter and of the threshold.

Ports:
- `clk_i` in 1: system clock, the single clock of the block.
- `rst_i` in 1: reset, synchronous, active-high.
- `out_i` in CH: core output value.
- `oe_i` in CH: core output enable, active-high.
- `od_i` in CH: per-channel open-drain mode select.
- `filt_thr_i` in FILT_W: debounce threshold, shared by all channels.
- `in_o` out CH: filtered, synchronised pad input.
- `rise_o` out CH: one-cycle pulse on each 0->1 change of `in_o`.
- `fall_o` out CH: one-cycle pulse on each 1->0 change of `in_o`.
- `pad_out_o` out CH: value to the tri-state buffer.
- `pad_oe_o` out CH: buffer drive enable, active-high.
- `pad_in_i` in CH: raw pad input, asynchronous.

## Operation
Output path, per channel, registered:
- Push-pull (`od_i`=0): `pad_out_o`<=`out_i`, `pad_oe_o`<=`oe_i`.
- Open-drain (`od_i`=1): `pad_out_o`<=0, `pad_oe_o`<=`oe_i & ~out_i`. The pad is driven low only; otherwise it is released.

Input path, per channel:
- The synchroniser is a SYNC_STAGES-deep flop chain; its last stage is `sync`.
- `in_o` is a registered stable value.
- `rise_o` and `fall_o` are registered in the same edge that updates `in_o`, so each pulse is coincident with the new `in_o` value.
- The update rule of `in_o` depends on the filter, described under Configuration.

Filter counter rules, per channel:
- If `sync`==`in_o`: `cnt`<=0.
- Else if `cnt`>=`filt_thr_i`: `in_o`<=`sync`, `cnt`<=0, and the matching edge pulse fires.
- Else: `cnt`<=`cnt`+1.

Boundary conditions:
- A glitch shorter than `filt_thr_i`+1 cycles at `sync` clears `cnt` and produces no `in_o` change and no pulse.
- Lowering `filt_thr_i` mid-count takes effect immediately through the `>=` compare. `cnt` never wraps, because it is bounded by 2^FILT_W-1.
- `filt_thr_i`=0 gives the minimum filter latency.
- The output and input paths are independent. A driven pad reads back through `pad_in_i` with full input latency; the block has no internal loopback.
- `rise_o` and `fall_o` are never both high on the same channel in the same cycle.

## Timing
- Reset: `rst_i` sampled high clears all sync flops, `cnt`, `in_o`, `rise_o`, `fall_o`, `pad_out_o` and `pad_oe_o` to 0 on the next edge.
- After reset, a pad held high is seen as a 0->1 change: one `rise_o` pulse fires after the input latency.
- Reset asserted mid-count discards the count; no pulse is generated for that channel.
- Output latency: 1 cycle from `out_i`/`oe_i`/`od_i` to the `pad_*` outputs.
- Input latency, pad edge to `in_o`/pulse:
  - with filter: SYNC_STAGES + `filt_thr_i` + 1 cycles, input held stable throughout;
  - without filter: SYNC_STAGES + 1 cycles.
- Edge pulses are exactly 1 cycle wide. The minimum spacing between same-channel pulses equals the filter latency after the synchroniser.

## Configuration
- `FPGA_GPIO_BANK_FILTER_EN` defined:
  - per-channel `cnt` counters are instantiated;
  - `in_o` follows the counter rules above.
- `FPGA_GPIO_BANK_FILTER_EN` undefined:
  - no counters are instantiated and `filt_thr_i` is ignored;
  - `in_o`<=`sync` every cycle;
  - edge pulses fire on every `sync` change.

## Test plan
- Reset: hold `rst_i`=1 for 3 cycles with `pad_in_i`=0 -> all outputs 0. Then release with `pad_in_i[0]`=1, SYNC_STAGES=2, `filt_thr_i`=3 -> `in_o[0]`=1 and `rise_o[0]` pulses exactly 6 cycles after the release edge.
- Debounce glitch: `filt_thr_i`=3, pulse `pad_in_i[5]` high for 3 cycles -> no change on `in_o[5]`, no pulse. A 4-cycle pulse -> `in_o[5]` rises, then falls, each edge with one pulse.
- Open-drain: `od_i[2]`=1, `oe_i[2]`=1, toggle `out_i[2]` 0/1 -> `pad_oe_o[2]` follows `~out_i[2]` one cycle later and `pad_out_o[2]` stays 0. With `od_i[2]`=0 -> `pad_out_o[2]`=`out_i[2]`, `pad_oe_o[2]`=1.
- Threshold lowered mid-count: `filt_thr_i`=15, raise `pad_in_i[1]`, wait until `cnt`=8, set `filt_thr_i`=4 -> `in_o[1]` updates on the next edge with one `rise_o` pulse.
- Multi-channel independence: CH=16, alternate pattern 0xA5A5 on `pad_in_i` -> `in_o`=0xA5A5 after the latency, and `rise_o`=0xA5A5 for exactly one cycle.
- Macro off: build without `FPGA_GPIO_BANK_FILTER_EN`, `filt_thr_i`=15, 1-cycle pad glitch -> `in_o` shows a 1-cycle pulse at SYNC_STAGES+1, with `rise_o` and then `fall_o` on consecutive cycles.

Source files
------------

// File: rtl/fpga_gpio_bank.sv
// rtl/fpga_gpio_bank.sv - registered GPIO pad bank: push-pull/open-drain outputs, synchronised inputs with edge pulses
// Define FPGA_GPIO_BANK_FILTER_EN to add the per-channel debounce filter on the input path.
module fpga_gpio_bank #(
  parameter int CH          = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CH-1:0]     out_i,
  input  logic [CH-1:0]     oe_i,
  input  logic [CH-1:0]     od_i,
  input  logic [FILT_W-1:0] filt_thr_i,
  output logic [CH-1:0]     in_o,
  output logic [CH-1:0]     rise_o,
  output logic [CH-1:0]     fall_o,
  output logic [CH-1:0]     pad_out_o,
  output logic [CH-1:0]     pad_oe_o,
  input  logic [CH-1:0]     pad_in_i
);

  logic [CH-1:0] sync_q [SYNC_STAGES];
  logic [CH-1:0] sync;
  logic [CH-1:0] in_q;
  logic [CH-1:0] in_d;
  logic [CH-1:0] rise_d;
  logic [CH-1:0] fall_d;

  // Open-drain channels only ever drive low; otherwise the pad is released.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pad_out_o <= '0;
      pad_oe_o  <= '0;
    end else begin
      pad_out_o <= out_i & ~od_i;
      pad_oe_o  <= oe_i & ~(od_i & out_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pad_in_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef FPGA_GPIO_BANK_FILTER_EN
  logic [FILT_W-1:0] cnt_q [CH];
  logic [FILT_W-1:0] cnt_d [CH];

  // Count only while sync disagrees with the accepted value; any agreement restarts the count.
  always_comb begin
    in_d = in_q;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync[i] == in_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= filt_thr_i) begin
        in_d[i]  = sync[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  logic unused_thr;

  assign unused_thr = ^filt_thr_i;
  assign in_d       = sync;
`endif

  assign rise_d = in_d & ~in_q;
  assign fall_d = ~in_d & in_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_q   <= '0;
      rise_o <= '0;
      fall_o <= '0;
    end else begin
      in_q   <= in_d;
      rise_o <= rise_d;
      fall_o <= fall_d;
    end
  end

  assign in_o = in_q;

endmodule

// File: tb/tb_fpga_gpio_bank.sv
// tb/tb_fpga_gpio_bank.sv - self-checking bench for fpga_gpio_bank (filter or plain build via FPGA_GPIO_BANK_FILTER_EN)
module tb_fpga_gpio_bank;

  localparam int CH = 16;
  localparam int SS = 2;
  localparam int FW = 4;
`ifdef FPGA_GPIO_BANK_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] out_v, oe_v, od_v, pad_in;
  logic [CH-1:0] in_v, rise, fall, pad_out, pad_oe;
  logic [FW-1:0] thr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] out;
    logic [15:0] oe;
    logic [15:0] od;
    logic [15:0] exp_out;
    logic [15:0] exp_oe;
  } ovec_t;

  typedef struct {
    int          due;
    logic [15:0] exp_out;
    logic [15:0] exp_oe;
  } sb_t;

  ovec_t tbl [10];
  sb_t   sb  [$];

  fpga_gpio_bank #(.CH(CH), .SYNC_STAGES(SS), .FILT_W(FW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .out_i      (out_v),
    .oe_i       (oe_v),
    .od_i       (od_v),
    .filt_thr_i (thr),
    .in_o       (in_v),
    .rise_o     (rise),
    .fall_o     (fall),
    .pad_out_o  (pad_out),
    .pad_oe_o   (pad_oe),
    .pad_in_i   (pad_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lat(input int t);
    return FILT ? SS + t + 1 : SS + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due == cyc) begin
      sb_t e;
      e = sb.pop_front();
      check("pad_out", {16'h0, pad_out}, {16'h0, e.exp_out});
      check("pad_oe", {16'h0, pad_oe}, {16'h0, e.exp_oe});
    end
  end

  task automatic pulse_watch(input int ch, input int width, input int window, input logic [15:0] others,
                             output int rises, output int falls, output int highs,
                             output int first_rise, output int first_fall, output int both, output int other_bad);
    logic [15:0] m;
    m = 16'h0001 << ch;
    rises = 0; falls = 0; highs = 0; first_rise = 0; first_fall = 0; both = 0; other_bad = 0;
    pad_in[ch] = 1'b1;
    for (int k = 1; k <= window; k++) begin
      step();
      if (rise[ch]) begin
        rises++;
        if (first_rise == 0) first_rise = k;
      end
      if (fall[ch]) begin
        falls++;
        if (first_fall == 0) first_fall = k;
      end
      if (in_v[ch]) highs++;
      if ((rise & fall) != 16'h0) both++;
      if ((in_v & ~m) != others) other_bad++;
      if (k == width) pad_in[ch] = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int first, nr, nf, nxt, inat, pulses;
    int rs, fs, hs, fr, ff, bo, ob;
    logic [15:0] rv, iv, nv;

    tbl[0] = '{16'h0000, 16'h0004, 16'h0004, 16'h0000, 16'h0004};
    tbl[1] = '{16'h0004, 16'h0004, 16'h0004, 16'h0000, 16'h0000};
    tbl[2] = '{16'h0000, 16'h0004, 16'h0004, 16'h0000, 16'h0004};
    tbl[3] = '{16'h0004, 16'h0004, 16'h0000, 16'h0004, 16'h0004};
    tbl[4] = '{16'h0000, 16'h0004, 16'h0000, 16'h0000, 16'h0004};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF};
    tbl[6] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    tbl[7] = '{16'h00FF, 16'h0F0F, 16'h3333, 16'h00CC, 16'h0F0C};
    tbl[8] = '{16'hA5A5, 16'h0000, 16'h5A5A, 16'hA5A5, 16'h0000};
    tbl[9] = '{16'h1234, 16'hFFFF, 16'h00FF, 16'h1200, 16'hFFCB};

    rst = 1'b1; pad_in = '0; out_v = '0; oe_v = '0; od_v = '0; thr = 4'd3;
    repeat (3) step();
    check("reset_in", {16'h0, in_v}, 32'h0);
    check("reset_rise", {16'h0, rise}, 32'h0);
    check("reset_fall", {16'h0, fall}, 32'h0);
    check("reset_pad_out", {16'h0, pad_out}, 32'h0);
    check("reset_pad_oe", {16'h0, pad_oe}, 32'h0);

    // Pad held high through reset release is seen as a rising edge.
    rst = 1'b0; pad_in = 16'h0001;
    first = 0; nr = 0; inat = 0; nxt = 1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (rise[0]) begin
        nr++;
        if (first == 0) begin
          first = k;
          inat  = int'(in_v[0]);
        end
      end
      if (first != 0 && k == first + 1) nxt = int'(rise[0]);
    end
    check("release_latency", first, lat(3));
    check("release_rise_count", nr, 1);
    check("release_in_at_rise", inat, 1);
    check("release_rise_width", nxt, 0);

    for (int i = 0; i < 10; i++) begin
      out_v = tbl[i].out; oe_v = tbl[i].oe; od_v = tbl[i].od;
      sb.push_back('{cyc + 1, tbl[i].exp_out, tbl[i].exp_oe});
      step();
    end
    out_v = '0; oe_v = '0; od_v = '0;
    step(); step();
    check("sb_drained", sb.size(), 0);

    thr = 4'd3;
    pulse_watch(5, 3, 25, 16'h0001, rs, fs, hs, fr, ff, bo, ob);
    check("glitch3_rises", rs, FILT ? 0 : 1);
    check("glitch3_falls", fs, FILT ? 0 : 1);
    check("glitch3_highs", hs, FILT ? 0 : 3);
    check("glitch3_first_rise", fr, FILT ? 0 : 3);
    check("glitch3_both", bo, 0);
    check("glitch3_others", ob, 0);

    pulse_watch(5, 4, 25, 16'h0001, rs, fs, hs, fr, ff, bo, ob);
    check("glitch4_rises", rs, 1);
    check("glitch4_falls", fs, 1);
    check("glitch4_highs", hs, 4);
    check("glitch4_first_rise", fr, FILT ? 6 : 3);
    check("glitch4_first_fall", ff, FILT ? 10 : 7);
    check("glitch4_both", bo, 0);
    check("glitch4_others", ob, 0);

    // Threshold lowered from 15 to 4 once cnt has reached 8.
    thr = 4'd15; pad_in[1] = 1'b1;
    first = 0; nr = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (rise[1]) begin
        nr++;
        if (first == 0) first = k;
      end
      if (k == 10) thr = 4'd4;
    end
    check("thr_lower_latency", first, FILT ? 11 : 3);
    check("thr_lower_rises", nr, 1);
    pad_in[1] = 1'b0;
    repeat (20) step();

    thr = 4'd15;
    pulse_watch(7, 1, 30, 16'h0001, rs, fs, hs, fr, ff, bo, ob);
    check("glitch1_rises", rs, FILT ? 0 : 1);
    check("glitch1_falls", fs, FILT ? 0 : 1);
    check("glitch1_highs", hs, FILT ? 0 : 1);
    check("glitch1_first_rise", fr, FILT ? 0 : 3);
    check("glitch1_first_fall", ff, FILT ? 0 : 4);
    check("glitch1_others", ob, 0);

    pad_in[3] = 1'b1;
    repeat (8) step();
    rst = 1'b1; pad_in = '0;
    step(); step();
    check("midreset_in", {16'h0, in_v}, 32'h0);
    check("midreset_rise", {16'h0, rise}, 32'h0);
    check("midreset_fall", {16'h0, fall}, 32'h0);
    rst = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 25; k++) begin
      step();
      if ((rise | fall) != 16'h0) pulses++;
    end
    check("midreset_no_pulse", pulses, 0);
    check("midreset_in_after", {16'h0, in_v}, 32'h0);

    thr = 4'd3; pad_in = 16'hA5A5;
    first = 0; nf = 0; rv = '0; iv = '0; nv = 16'hFFFF;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (rise != 16'h0 && first == 0) begin
        first = k; rv = rise; iv = in_v;
      end else if (first != 0 && k == first + 1) begin
        nv = rise;
      end
      if (fall != 16'h0) nf++;
    end
    check("multi_latency", first, lat(3));
    check("multi_rise", {16'h0, rv}, 32'h0000A5A5);
    check("multi_in", {16'h0, iv}, 32'h0000A5A5);
    check("multi_rise_width", {16'h0, nv}, 32'h0);
    check("multi_no_fall", nf, 0);
    check("multi_in_final", {16'h0, in_v}, 32'h0000A5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
